// File: rtl/axi_tg_pkg.sv
// Shared definitions for the AXI traffic generator: FSM states, run modes and
// the address-derived data pattern used by both the writer and the checker.
package axi_tg_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_AW   = 3'd1;
    localparam logic [2:0] ST_W    = 3'd2;
    localparam logic [2:0] ST_B    = 3'd3;
    localparam logic [2:0] ST_AR   = 3'd4;
    localparam logic [2:0] ST_R    = 3'd5;
    localparam logic [2:0] ST_DONE = 3'd6;

    localparam logic [1:0] MODE_WR   = 2'd0;
    localparam logic [1:0] MODE_RD   = 2'd1;
    localparam logic [1:0] MODE_WRRD = 2'd2;

    // Widest supported case; callers truncate to their own data width.
    function automatic logic [127:0] exp_data(input logic [63:0] addr, input logic [127:0] seed);
        return {64'd0, addr} ^ seed;
    endfunction

endpackage

// File: rtl/axi_tg_checker.sv
// Read-data / response checker: counts pattern mismatches, misplaced rlast and
// bad write responses into a saturating counter and latches the first bad address.
module axi_tg_checker
    import axi_tg_pkg::*;
#(
    parameter int          ADDR_WIDTH = 16,
    parameter int          DATA_WIDTH = 32,
    parameter logic [7:0]  BURST_LEN  = 8'd7
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  clr,
    input  logic                  r_hs,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [DATA_WIDTH-1:0] exp_rdata,
    input  logic                  rlast,
    input  logic [7:0]            beat,
    input  logic [ADDR_WIDTH-1:0] beat_addr,
    input  logic                  b_hs,
    input  logic [1:0]            bresp,
    input  logic [ADDR_WIDTH-1:0] burst_addr,
    output logic [15:0]           err_cnt,
    output logic [ADDR_WIDTH-1:0] first_err_addr
);

    logic                  data_err, last_err, resp_err;
    logic [1:0]            inc;
    logic [16:0]           sum;
    logic [15:0]           err_cnt_q, err_cnt_d;
    logic [ADDR_WIDTH-1:0] first_q, first_d;

    assign data_err = r_hs && (rdata != exp_rdata);
    // A late rlast is not counted again: the missing one already was.
    assign last_err = r_hs && ((rlast && (beat < BURST_LEN)) || (!rlast && (beat == BURST_LEN)));
    assign resp_err = b_hs && (bresp != 2'b00);
    assign inc      = 2'(data_err) + 2'(last_err) + 2'(resp_err);
    assign sum      = {1'b0, err_cnt_q} + 17'(inc);

    always_comb begin
        err_cnt_d = sum[16] ? 16'hFFFF : sum[15:0];
        first_d   = first_q;
        if (clr) begin
            err_cnt_d = 16'd0;
        end else if ((err_cnt_q == 16'd0) && (inc != 2'd0)) begin
            first_d = resp_err ? burst_addr : beat_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            err_cnt_q <= 16'd0;
            first_q   <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
            first_q   <= first_d;
        end
    end

    assign err_cnt        = err_cnt_q;
    assign first_err_addr = first_q;

endmodule

// File: rtl/axi_traffic_gen.sv
// AXI traffic generator: NUM_BURSTS incrementing bursts of pattern writes,
// read-backs, or both, with every read beat checked by axi_tg_checker.
module axi_traffic_gen
    import axi_tg_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 16,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DATA_LEVEL = 2,
    parameter logic [7:0]            BURST_LEN  = 8'd7,
    parameter int                    NUM_BURSTS = 16,
    parameter logic [DATA_WIDTH-1:0] SEED       = '0
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [ADDR_WIDTH-1:0] awaddr,
    output logic [7:0]            awlen,
    output logic                  wvalid,
    input  logic                  wready,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic                  wlast,
    input  logic                  bvalid,
    output logic                  bready,
    input  logic [1:0]            bresp,
    output logic                  arvalid,
    input  logic                  arready,
    output logic [ADDR_WIDTH-1:0] araddr,
    output logic [7:0]            arlen,
    input  logic                  rvalid,
    output logic                  rready,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic                  rlast,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           err_cnt,
    output logic [ADDR_WIDTH-1:0] first_err_addr
);

    localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'((32'(BURST_LEN) + 32'd1) << DATA_LEVEL);

    logic [2:0]            state_q, state_d;
    logic [1:0]            mode_q, mode_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d, addr_q, addr_d, beat_addr;
    logic [7:0]            beat_q, beat_d;
    logic [31:0]           burst_q, burst_d;
    logic [DATA_WIDTH-1:0] exp_beat;
    logic                  last_burst, clr, r_hs, b_hs;

    assign beat_addr  = addr_q + ADDR_WIDTH'(32'(beat_q) << DATA_LEVEL);
    assign exp_beat   = DATA_WIDTH'(exp_data(64'(beat_addr), 128'(SEED)));
    assign last_burst = (burst_q + 32'd1) >= 32'(NUM_BURSTS);

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        base_d  = base_q;
        addr_d  = addr_q;
        beat_d  = beat_q;
        burst_d = burst_q;
        clr     = 1'b0;
        case (state_q)
            ST_IDLE: if (start) begin
                mode_d  = mode;
                base_d  = base_addr;
                addr_d  = base_addr;
                beat_d  = 8'd0;
                burst_d = 32'd0;
                clr     = 1'b1;
                state_d = (mode == MODE_RD) ? ST_AR : ST_AW;
            end
            ST_AW: if (awready) begin
                beat_d  = 8'd0;
                state_d = ST_W;
            end
            ST_W: if (wready) begin
                if (beat_q == BURST_LEN) state_d = ST_B;
                else                     beat_d  = beat_q + 8'd1;
            end
            ST_B: if (bvalid) begin
                addr_d  = addr_q + STEP;
                burst_d = burst_q + 32'd1;
                if (!last_burst) begin
                    state_d = ST_AW;
                end else if (mode_q != MODE_WR) begin
                    // Mode 3 falls here too and behaves as write-then-read.
                    addr_d  = base_q;
                    burst_d = 32'd0;
                    state_d = ST_AR;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_AR: if (arready) begin
                beat_d  = 8'd0;
                state_d = ST_R;
            end
            ST_R: if (rvalid) begin
                if (rlast) begin
                    addr_d  = addr_q + STEP;
                    burst_d = burst_q + 32'd1;
                    state_d = last_burst ? ST_DONE : ST_AR;
                end else begin
                    beat_d = beat_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_WR;
            base_q  <= '0;
            addr_q  <= '0;
            beat_q  <= 8'd0;
            burst_q <= 32'd0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            base_q  <= base_d;
            addr_q  <= addr_d;
            beat_q  <= beat_d;
            burst_q <= burst_d;
        end
    end

    assign awvalid = (state_q == ST_AW);
    assign awaddr  = addr_q;
    assign awlen   = BURST_LEN;
    assign wvalid  = (state_q == ST_W);
    assign wdata   = exp_beat;
    assign wlast   = (beat_q == BURST_LEN);
    assign bready  = (state_q == ST_B);
    assign arvalid = (state_q == ST_AR);
    assign araddr  = addr_q;
    assign arlen   = BURST_LEN;
    assign rready  = (state_q == ST_R);
    assign busy    = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done    = (state_q == ST_DONE);
    assign r_hs    = rvalid && rready;
    assign b_hs    = bvalid && bready;

    axi_tg_checker #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .BURST_LEN  (BURST_LEN)
    ) u_checker (
        .clk            (clk),
        .rstn           (rstn),
        .clr            (clr),
        .r_hs           (r_hs),
        .rdata          (rdata),
        .exp_rdata      (exp_beat),
        .rlast          (rlast),
        .beat           (beat_q),
        .beat_addr      (beat_addr),
        .b_hs           (b_hs),
        .bresp          (bresp),
        .burst_addr     (addr_q),
        .err_cnt        (err_cnt),
        .first_err_addr (first_err_addr)
    );

endmodule
